branch_ctrl: RTL and testbench

//  Fetch-side branch controller; the consumer end of the program counter's branch interface.

---
 rtl/branch_ctrl.sv | 120 ++++++++++++
 tb/tb_branch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Fetch-side branch controller: waits out ROM latency after each PC change, decodes the
// fetched instruction and drives a registered absolute jump (branchFlag/target) from a writable LUT.
module branch_ctrl #(
  parameter int D        = 12,
  parameter int W        = 9,
  parameter int LUT_AW   = 4,
  parameter int IMEM_LAT = 1,
  parameter int HOLD_CYC = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [D-1:0]      prog_ctr,
  input  logic [W-1:0]      instr,
  input  logic              cond_flag,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [D-1:0]      lut_wdata,
  output logic              branchFlag,
  output logic [D-1:0]      target,
  output logic              busy
);

  localparam int MAXC = (HOLD_CYC > IMEM_LAT) ? HOLD_CYC : IMEM_LAT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(IMEM_LAT - 1);
  localparam logic [CW-1:0] CHG_LOAD  = CW'((IMEM_LAT > 1) ? IMEM_LAT - 2 : 0);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DECODE, HOLD} state_t;

  state_t            state;
  state_t            chg_state;
  logic [CW-1:0]     cnt;
  logic [D-1:0]      last_pc;
  logic [D-1:0]      lut [2**LUT_AW];
  logic              pc_chg;
  logic              is_branch;
  logic              cond_ok;
  logic              taken;

  assign pc_chg = (prog_ctr != last_pc);
  assign busy   = (state != IDLE);

  // The cycle in which a new PC first appears already counts as the first
  // ROM-latency cycle, so a one-cycle ROM goes straight to DECODE.
  assign chg_state = (IMEM_LAT == 1) ? DECODE : WAIT;

  always_comb begin
    is_branch = (instr[W-1 -: 3] == 3'b111);
    cond_ok   = 1'b0;
    case (instr[5:4])
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = cond_flag;
      2'b10:   cond_ok = !cond_flag;
      default: cond_ok = 1'b0;
    endcase
    taken = is_branch && cond_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT;
      cnt        <= '0;
      branchFlag <= 1'b0;
      target     <= '0;
      last_pc    <= prog_ctr;
      for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
    end else begin
      last_pc <= prog_ctr;
      if (lut_we) lut[lut_waddr] <= lut_wdata;
      case (state)
        IDLE: begin
          if (pc_chg) begin
            state <= chg_state;
            cnt   <= CHG_LOAD;
          end
        end
        WAIT: begin
          if (pc_chg) begin
            state <= chg_state;
            cnt   <= CHG_LOAD;
          end else if (cnt == '0) begin
            state <= DECODE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DECODE: begin
          if (pc_chg) begin
            state <= chg_state;
            cnt   <= CHG_LOAD;
          end else if (taken) begin
            branchFlag <= 1'b1;
            target     <= lut[instr[LUT_AW-1:0]];
            cnt        <= HOLD_LOAD;
            state      <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (pc_chg) begin
            branchFlag <= 1'b0;
            state      <= chg_state;
            cnt        <= CHG_LOAD;
          end else if (cnt == '0) begin
            // Timeout re-fetches the same PC; this releases self-loops.
            branchFlag <= 1'b0;
            state      <= WAIT;
            cnt        <= WAIT_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: table of single-fetch vectors plus hand sequences
// for hold release, LUT read-before-write, self-loop timeout and mid-hold reset.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_ctr;
  logic [8:0]  instr;
  logic        cond_flag;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic        branchFlag;
  logic [11:0] target;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [11:0] pc;
    logic [8:0]  ins;
    logic        cond;
    logic        bf;
    logic [11:0] tgt;
  } vec_t;

  vec_t vecs [10];

  branch_ctrl dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .instr(instr),
    .cond_flag(cond_flag), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .branchFlag(branchFlag), .target(target), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic lut_wr(input logic [3:0] a, input logic [11:0] d);
    lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
    step();
    lut_we = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    prog_ctr = v.pc; instr = v.ins; cond_flag = v.cond;
    step();
    step();
    chk($sformatf("vec%0d_bf", idx), 32'(branchFlag), 32'(v.bf));
    chk($sformatf("vec%0d_target", idx), 32'(target), 32'(v.tgt));
    chk($sformatf("vec%0d_busy", idx), 32'(busy), 32'(v.bf));
    if (v.bf) begin
      prog_ctr = v.pc + 12'd100; instr = '0;
      step();
      chk($sformatf("vec%0d_release", idx), 32'(branchFlag), 32'd0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc;
    int lc;
    vecs[0] = '{12'h020, 9'b000_00_0011, 1'b0, 1'b0, 12'h000};
    vecs[1] = '{12'h021, 9'b111_00_0001, 1'b0, 1'b1, 12'h7FF};
    vecs[2] = '{12'h022, 9'b111_01_0011, 1'b0, 1'b0, 12'h7FF};
    vecs[3] = '{12'h023, 9'b111_01_0011, 1'b1, 1'b1, 12'h0A5};
    vecs[4] = '{12'h024, 9'b111_10_1111, 1'b0, 1'b1, 12'hF0F};
    vecs[5] = '{12'h025, 9'b111_10_1111, 1'b1, 1'b0, 12'hF0F};
    vecs[6] = '{12'h026, 9'b111_11_0001, 1'b1, 1'b0, 12'hF0F};
    vecs[7] = '{12'h027, 9'b110_00_0001, 1'b0, 1'b0, 12'hF0F};
    vecs[8] = '{12'h028, 9'b011_00_0011, 1'b1, 1'b0, 12'hF0F};
    vecs[9] = '{12'h029, 9'b111_00_0000, 1'b0, 1'b1, 12'h000};

    reset = 1'b1; prog_ctr = '0; instr = '0; cond_flag = 1'b0;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    step();
    step();
    chk("reset_bf", 32'(branchFlag), 32'd0);
    chk("reset_target", 32'(target), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    step();
    chk("post_reset_busy1", 32'(busy), 32'd1);
    step();
    chk("post_reset_busy2", 32'(busy), 32'd0);
    chk("post_reset_bf", 32'(branchFlag), 32'd0);

    lut_wr(4'd3, 12'h0A5);
    lut_wr(4'd1, 12'h7FF);
    lut_wr(4'd15, 12'hF0F);
    lut_wr(4'd2, 12'h010);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // PC 4 -> 5 with an unconditional branch; released when PC reaches the target
    prog_ctr = 12'h004; instr = '0;
    step(); step(); step();
    prog_ctr = 12'h005; instr = 9'b111_00_0011;
    step();
    chk("t2_bf_n1", 32'(branchFlag), 32'd0);
    step();
    chk("t2_bf_n2", 32'(branchFlag), 32'd1);
    chk("t2_target", 32'(target), 32'h0A5);
    step(); step(); step();
    chk("t2_held_bf", 32'(branchFlag), 32'd1);
    chk("t2_held_target", 32'(target), 32'h0A5);
    prog_ctr = 12'h0A5; instr = '0;
    step();
    chk("t2_release", 32'(branchFlag), 32'd0);
    step(); step();
    chk("t2_idle", 32'(busy), 32'd0);

    // LUT write during the DECODE cycle returns the old entry
    prog_ctr = 12'h030; instr = 9'b111_00_0011;
    step();
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'h111;
    step();
    lut_we = 1'b0;
    chk("t4_old_bf", 32'(branchFlag), 32'd1);
    chk("t4_old_target", 32'(target), 32'h0A5);
    prog_ctr = 12'h031; instr = '0;
    step(); step();
    prog_ctr = 12'h030; instr = 9'b111_00_0011;
    step(); step();
    chk("t4_new_target", 32'(target), 32'h111);
    prog_ctr = 12'h032; instr = '0;
    step(); step();

    // Self-loop: hold timeout, brief drop, re-assert
    prog_ctr = 12'h010; instr = 9'b111_00_0010;
    step(); step();
    hc = 0;
    while (branchFlag === 1'b1 && hc < 40) begin
      hc++;
      step();
    end
    chk("t5_high_cycles", 32'(hc), 32'd12);
    lc = 0;
    while (branchFlag === 1'b0 && lc < 40) begin
      lc++;
      step();
    end
    chk("t5_low_cycles", 32'(lc), 32'd2);
    chk("t5_reassert", 32'(branchFlag), 32'd1);
    chk("t5_target", 32'(target), 32'h010);

    // Reset in the middle of HOLD
    step(); step();
    reset = 1'b1;
    step();
    chk("t6_bf", 32'(branchFlag), 32'd0);
    chk("t6_target", 32'(target), 32'd0);
    chk("t6_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    step(); step();
    chk("t6_refetch_bf", 32'(branchFlag), 32'd1);
    chk("t6_lut_cleared", 32'(target), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
